// File: rtl/vending_controller_pkg.sv
// vending_controller_pkg
//   Shared definitions for the vending controller: coin codes, coin values
//   in cents, and the controller state encoding.
package vending_controller_pkg;

  // Coin codes as presented on the coin input and the change_coin output.
  localparam logic [2:0] COIN_NONE    = 3'd0;
  localparam logic [2:0] COIN_NICKEL  = 3'd1;
  localparam logic [2:0] COIN_DIME    = 3'd2;
  localparam logic [2:0] COIN_QUARTER = 3'd3;
  localparam logic [2:0] COIN_DOLLAR  = 3'd4;

  // Coin values in cents. Seven bits hold the largest coin (100).
  localparam int COIN_VAL_W = 7;
  localparam logic [COIN_VAL_W-1:0] VAL_NICKEL  = 7'd5;
  localparam logic [COIN_VAL_W-1:0] VAL_DIME    = 7'd10;
  localparam logic [COIN_VAL_W-1:0] VAL_QUARTER = 7'd25;
  localparam logic [COIN_VAL_W-1:0] VAL_DOLLAR  = 7'd100;

  // ST_IDLE: credit is zero. ST_CREDIT: credit above zero, accepting
  // coins/requests. ST_VEND: one-cycle dispense. ST_CHANGE: paying out.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } vend_state_t;

endpackage

// File: rtl/vending_controller_coin_decode.sv
// vend_coin_decode
//   Combinational coin code to value map. Used both for inserted coins and
//   for the coin chosen by the change path.
// Ports:
//   code   in  3          coin code
//   value  out COIN_VAL_W value in cents (0 for none/invalid)
//   valid  out 1          code is a real coin (nickel..dollar)
module vend_coin_decode
  import vending_controller_pkg::*;
(
  input  logic [2:0]            code,
  output logic [COIN_VAL_W-1:0] value,
  output logic                  valid
);

  always_comb begin
    value = '0;
    valid = 1'b0;
    case (code)
      COIN_NICKEL:  begin value = VAL_NICKEL;  valid = 1'b1; end
      COIN_DIME:    begin value = VAL_DIME;    valid = 1'b1; end
      COIN_QUARTER: begin value = VAL_QUARTER; valid = 1'b1; end
      COIN_DOLLAR:  begin value = VAL_DOLLAR;  valid = 1'b1; end
      default:      begin value = '0;          valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/vending_controller.sv
// vending_controller
//   Multi-product vending controller: accepts coins, tracks credit in cents,
//   vends one of NUM_PRODUCTS items at per-item prices, and pays change back
//   one coin per cycle (greedy quarter/dime/nickel). All outputs registered.
// Ports:
//   clk50         in  1         system clock, rising edge
//   reset         in  1         asynchronous active-high reset
//   coin          in  3         coin code (0 none, 1..4 coins, 5..7 invalid)
//   product       in  PROD_W    0 none, k selects item k-1
//   cancel        in  1         refund request (level)
//   dispense      out 1         one-cycle vend pulse
//   item          out PROD_W    index+1 of last vended item
//   credit        out CREDIT_W  current credit in cents
//   change_valid  out 1         a change coin is ejected this cycle
//   change_coin   out 3         code of the ejected coin
//   coin_reject   out 1         one-cycle pulse, inserted coin returned
//   busy          out 1         high in VEND and CHANGE
//
// Output strobes: dispense, change_valid and coin_reject are single-cycle
// valid pulses with no ready/back-pressure; the actuators must accept every
// pulse. item/change_coin are meaningful only while their strobe is high.
module vending_controller
  import vending_controller_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int PROD_W       = 4,
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 200,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd100, 8'd75, 8'd50, 8'd35}
) (
  input  logic                clk50,
  input  logic                reset,
  input  logic [2:0]          coin,
  input  logic [PROD_W-1:0]   product,
  input  logic                cancel,
  output logic                dispense,
  output logic [PROD_W-1:0]   item,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [2:0]          change_coin,
  output logic                coin_reject,
  output logic                busy
);

  vend_state_t state, state_nx;

  logic [2:0] coin_q;
  logic       prod_armed;

  logic                  coin_evt;
  logic [COIN_VAL_W-1:0] coin_value;
  logic                  coin_ok;
  logic [CREDIT_W:0]     coin_sum;
  logic                  coin_fits;

  logic                prod_valid;
  logic                prod_req;
  logic [CREDIT_W-1:0] sel_price;

  logic [2:0]            chg_code;
  logic [COIN_VAL_W-1:0] chg_value;
  logic                  chg_ok;

  // Actions chosen by the next-state logic for this cycle.
  logic accept_coin, reject_coin, do_vend, eject;

  logic [CREDIT_W-1:0] credit_nx;
  logic [PROD_W-1:0]   item_nx;
  logic [2:0]          change_coin_nx;
  logic                dispense_nx, change_valid_nx, coin_reject_nx, busy_nx, armed_nx;

  // A coin counts only on the cycle its code first appears after a zero.
  assign coin_evt = (coin != COIN_NONE) && (coin_q == COIN_NONE);

  vend_coin_decode u_coin_decode (
    .code  (coin),
    .value (coin_value),
    .valid (coin_ok)
  );

  // One extra bit so credit + dollar cannot wrap before the ceiling test.
  assign coin_sum  = (CREDIT_W+1)'(credit) + (CREDIT_W+1)'(coin_value);
  assign coin_fits = coin_ok && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // Price lookup; out-of-range product codes leave prod_valid low.
  always_comb begin
    sel_price  = '0;
    prod_valid = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (product == PROD_W'(i + 1)) begin
        sel_price  = PRICES[i*CREDIT_W +: CREDIT_W];
        prod_valid = 1'b1;
      end
    end
  end

  assign prod_req = prod_valid && prod_armed;

  // Greedy change coin for the current credit. Credit is always a multiple
  // of 5, so the nickel branch is only reached with exactly 5 left.
  always_comb begin
    if (credit >= CREDIT_W'(VAL_QUARTER))   chg_code = COIN_QUARTER;
    else if (credit >= CREDIT_W'(VAL_DIME)) chg_code = COIN_DIME;
    else                                    chg_code = COIN_NICKEL;
  end

  vend_coin_decode u_change_decode (
    .code  (chg_code),
    .value (chg_value),
    .valid (chg_ok)
  );

  // State register.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and per-cycle action selection.
  // In CREDIT the priority is cancel > coin > product; a product request
  // losing to a coin is simply re-evaluated next cycle if still held.
  // The first change coin is ejected on the edge that enters CHANGE, so
  // every CHANGE cycle carries exactly one coin.
  always_comb begin
    state_nx    = state;
    accept_coin = 1'b0;
    reject_coin = 1'b0;
    do_vend     = 1'b0;
    eject       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coin_evt) begin
          if (coin_fits) begin
            accept_coin = 1'b1;
            state_nx    = ST_CREDIT;
          end else begin
            reject_coin = 1'b1;
          end
        end
      end
      ST_CREDIT: begin
        if (cancel) begin
          // A coin arriving with the cancel is handed straight back.
          reject_coin = coin_evt;
          eject       = 1'b1;
          state_nx    = ST_CHANGE;
        end else if (coin_evt) begin
          if (coin_fits) accept_coin = 1'b1;
          else           reject_coin = 1'b1;
        end else if (prod_req && (credit >= sel_price)) begin
          do_vend  = 1'b1;
          state_nx = ST_VEND;
        end
      end
      ST_VEND: begin
        reject_coin = coin_evt;
        if (credit != '0) begin
          eject    = 1'b1;
          state_nx = ST_CHANGE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        reject_coin = coin_evt;
        if (credit != '0) eject    = 1'b1;
        else              state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output/data next values from the chosen actions.
  always_comb begin
    credit_nx = credit;
    if (accept_coin) credit_nx = coin_sum[CREDIT_W-1:0];
    if (do_vend)     credit_nx = credit - sel_price;
    if (eject)       credit_nx = credit - CREDIT_W'(chg_value);

    item_nx         = do_vend ? product : item;
    dispense_nx     = do_vend;
    change_valid_nx = eject && chg_ok;
    change_coin_nx  = eject ? chg_code : COIN_NONE;
    coin_reject_nx  = reject_coin;
    busy_nx         = (state_nx == ST_VEND) || (state_nx == ST_CHANGE);

    // Re-arm only after product returns to 0, so a held button vends once.
    if (do_vend)                 armed_nx = 1'b0;
    else if (product == '0)      armed_nx = 1'b1;
    else                         armed_nx = prod_armed;
  end

  // Registered outputs and datapath. coin_q resets to all-ones so a coin
  // held across reset release is never seen as a fresh insertion.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      credit       <= '0;
      item         <= '0;
      dispense     <= 1'b0;
      change_valid <= 1'b0;
      change_coin  <= COIN_NONE;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
      coin_q       <= 3'b111;
      prod_armed   <= 1'b0;
    end else begin
      credit       <= credit_nx;
      item         <= item_nx;
      dispense     <= dispense_nx;
      change_valid <= change_valid_nx;
      change_coin  <= change_coin_nx;
      coin_reject  <= coin_reject_nx;
      busy         <= busy_nx;
      coin_q       <= coin;
      prod_armed   <= armed_nx;
    end
  end

endmodule

// File: tb/tb_vending_controller.sv
module tb_vending_controller;

  localparam int NUM_PRODUCTS = 4;
  localparam int PROD_W       = 4;
  localparam int CREDIT_W     = 8;
  localparam int MAX_CREDIT   = 200;
  localparam logic [7:0] EV_REJ = 8'h10;

  // ---------------- clock / reset ----------------
  logic clk50 = 1'b0;
  logic reset;
  logic [2:0] coin;
  logic [PROD_W-1:0] product;
  logic cancel;
  logic dispense;
  logic [PROD_W-1:0] item;
  logic [CREDIT_W-1:0] credit;
  logic change_valid;
  logic [2:0] change_coin;
  logic coin_reject;
  logic busy;

  always #10 clk50 = ~clk50;

  vending_controller #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .PROD_W       (PROD_W),
    .CREDIT_W     (CREDIT_W),
    .MAX_CREDIT   (MAX_CREDIT),
    .PRICES       ({8'd100, 8'd75, 8'd50, 8'd35})
  ) dut (
    .clk50        (clk50),
    .reset        (reset),
    .coin         (coin),
    .product      (product),
    .cancel       (cancel),
    .dispense     (dispense),
    .item         (item),
    .credit       (credit),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .coin_reject  (coin_reject),
    .busy         (busy)
  );

  // ---------------- reference model ----------------
  int checks   = 0;
  int failures = 0;
  int m_credit = 0;
  int price_tab [NUM_PRODUCTS] = '{35, 50, 75, 100};
  logic [7:0] exp_q[$];

  function automatic int coin_val(input logic [2:0] c);
    case (c)
      3'd1:    return 5;
      3'd2:    return 10;
      3'd3:    return 25;
      3'd4:    return 100;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] ev_disp(input int k);
    return {4'h2, 4'(k)};
  endfunction

  function automatic logic [7:0] ev_chg(input logic [2:0] c);
    return {4'h3, 1'b0, c};
  endfunction

  // Pushes the expected greedy payout for amount c; returns the coin count.
  function automatic int push_change(input int c);
    int q, d, n;
    q = c / 25;
    d = (c % 25) / 10;
    n = ((c % 25) % 10) / 5;
    for (int i = 0; i < q; i++) exp_q.push_back(ev_chg(3'd3));
    for (int i = 0; i < d; i++) exp_q.push_back(ev_chg(3'd2));
    for (int i = 0; i < n; i++) exp_q.push_back(ev_chg(3'd1));
    return q + d + n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic sb_pop(input string name, input logic [7:0] act);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event 0x%0h, none expected (t=%0t)", name, act, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'd0, act}, {24'd0, e});
    end
  endtask

  always @(negedge clk50) begin
    if (!reset) begin
      if (coin_reject)  sb_pop("coin_reject", EV_REJ);
      if (dispense)     sb_pop("dispense", {4'h2, item});
      if (change_valid) sb_pop("change_coin", ev_chg(change_coin));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic wait_not_busy(output int cnt);
    int idle_run;
    idle_run = 0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk50);
      if (busy) begin
        cnt++;
        idle_run = 0;
      end else begin
        idle_run++;
        if (cnt > 0 || idle_run >= 3) break;
      end
    end
  endtask

  task automatic insert(input logic [2:0] code, input int hold);
    int v;
    v = coin_val(code);
    if (v == 0 || m_credit + v > MAX_CREDIT) exp_q.push_back(EV_REJ);
    else m_credit += v;
    coin = code;
    repeat (hold) step();
    coin = 3'd0;
    step();
    @(negedge clk50);
    check("credit_after_coin", credit, m_credit);
  endtask

  task automatic buy(input int k);
    int cnt, exp_busy;
    exp_busy = 0;
    product = '0;
    step();
    if (k >= 1 && k <= NUM_PRODUCTS && m_credit > 0 && m_credit >= price_tab[k-1]) begin
      m_credit -= price_tab[k-1];
      exp_q.push_back(ev_disp(k));
      exp_busy = 1 + push_change(m_credit);
      m_credit = 0;
    end
    product = PROD_W'(k);
    wait_not_busy(cnt);
    product = '0;
    step();
    check("busy_cycles_buy", cnt, exp_busy);
    check("credit_after_buy", credit, m_credit);
  endtask

  task automatic do_cancel();
    int cnt, n;
    n = push_change(m_credit);
    m_credit = 0;
    cancel = 1'b1;
    wait_not_busy(cnt);
    cancel = 1'b0;
    step();
    check("busy_cycles_cancel", cnt, n);
    check("credit_after_cancel", credit, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    reset   = 1'b1;
    coin    = 3'd3;   // held through reset release: must not count
    product = '0;
    cancel  = 1'b0;
    repeat (3) @(posedge clk50);
    @(negedge clk50);
    check("reset_credit", credit, 0);
    check("reset_dispense", dispense, 0);
    check("reset_change_valid", change_valid, 0);
    check("reset_coin_reject", coin_reject, 0);
    check("reset_busy", busy, 0);
    check("reset_item", item, 0);
    step();
    reset = 1'b0;
    repeat (3) step();
    coin = 3'd0;
    step();
    @(negedge clk50);
    check("held_coin_over_reset", credit, 0);

    // dime + quarter, item 1 at 35: exact payment, no change
    insert(3'd2, 3);
    insert(3'd3, 3);
    buy(1);

    // dollar, item 2 at 50: two quarters back
    insert(3'd4, 1);
    buy(2);

    // quarter, dime, cancel: quarter then dime refunded
    insert(3'd3, 2);
    insert(3'd2, 1);
    do_cancel();

    // ceiling and invalid codes
    insert(3'd4, 1);
    insert(3'd4, 1);
    insert(3'd1, 1);
    insert(3'd6, 2);

    // reset in the middle of paying out 200 as quarters
    void'(push_change(m_credit));
    cancel = 1'b1;
    repeat (3) @(posedge clk50);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_change_valid", change_valid, 0);
    check("reset_mid_change_credit", credit, 0);
    check("reset_mid_change_busy", busy, 0);
    exp_q.delete();
    m_credit = 0;
    cancel = 1'b0;
    step();
    reset = 1'b0;
    step();

    // product 4 held with 50 credit, then dollar: vend one cycle after 150
    insert(3'd3, 1);
    insert(3'd3, 1);
    product = '0;
    step();
    product = 4'd4;
    repeat (3) step();
    @(negedge clk50);
    check("held_short_credit", credit, 50);
    exp_q.push_back(ev_disp(4));
    void'(push_change(50));
    step();
    coin = 3'd4;
    @(posedge clk50);
    @(negedge clk50);
    check("credit_reaches_150", credit, 150);
    check("no_dispense_with_coin", dispense, 0);
    @(posedge clk50);
    @(negedge clk50);
    check("dispense_next_cycle", dispense, 1);
    check("credit_after_price", credit, 50);
    coin = 3'd0;
    wait_not_busy(cnt);
    check("change_cycles_after_vend", cnt, 2);
    m_credit = 0;
    // item 1 held without returning to 0: no vend until re-armed
    product = 4'd1;
    insert(3'd3, 1);
    insert(3'd2, 1);
    repeat (3) step();
    check("no_rearm_credit_held", credit, 35);
    buy(1);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4)      insert(3'($urandom_range(1, 7)), $urandom_range(1, 3));
      else if (op <= 7) buy($urandom_range(1, 15));
      else              do_cancel();
    end
    do_cancel();

    repeat (2) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
